dma_scheduler: RTL and testbench

Multi-channel sequencer in front of the memory write port that serves the peripheral-to-memory DMA path. Up to NCH peripheral channels each get a programmed destination window (base, length). The block arbitrates between pending requests, generates one memory write per granted request, and advances each channel's address. Address 8'hFF is the reserved I/O address and is never written.

---
 rtl/dma_scheduler.sv | 139 +++++++++++++
 tb/tb_dma_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_scheduler.sv
// rtl/dma_scheduler.sv - multi-channel DMA write sequencer with per-channel destination windows
// Build option DMA_SCHED_FIXED_PRIO_EN: lowest-index fixed priority instead of round-robin.
module dma_scheduler #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                   clock_reg,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*DATA_W-1:0]  data_in,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W-1:0]      cfg_len,
  output logic [NCH-1:0]         ack,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_data,
  output logic [NCH-1:0]         done,
  output logic                   busy,
  output logic                   err
);
  localparam int IDX_W = $clog2(NCH);
  localparam logic [ADDR_W-1:0] RSVD_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [NCH-1:0]    ACK_ONE   = NCH'(1);

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;

  logic [ADDR_W-1:0] base [NCH];
  logic [ADDR_W-1:0] len  [NCH];
  logic [ADDR_W-1:0] cnt  [NCH];
  logic [DATA_W-1:0] ch_data [NCH];
  logic [NCH-1:0]    active;
  logic [NCH-1:0]    elig;
  logic [IDX_W-1:0]  win_c;
  logic [IDX_W-1:0]  win_q;
  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              cfg_hits_win;

  assign elig         = req & active;
  assign addr_c       = base[win_c] + cnt[win_c];
  assign cnt_nxt      = cnt[win_q] + ADDR_ONE;
  assign cfg_hits_win = cfg_we && (cfg_ch == win_q);

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_data[i] = data_in[i*DATA_W +: DATA_W];
  end

`ifdef DMA_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_c = '0;
    for (int j = NCH - 1; j >= 0; j--)
      if (elig[j]) win_c = IDX_W'(j);
  end
`else
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NCH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  logic [IDX_W-1:0] rr_ptr;

  // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx   = 0;
    win_c = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      idx = (int'(rr_ptr) + j) % NCH;
      if (elig[idx]) win_c = IDX_W'(idx);
    end
  end
`endif

  always_ff @(posedge clock_reg or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ack      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      done     <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      win_q    <= '0;
      active   <= '0;
      for (int i = 0; i < NCH; i++) begin
        base[i] <= '0;
        len[i]  <= '0;
        cnt[i]  <= '0;
      end
`ifndef DMA_SCHED_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|elig) begin
            state    <= WRITE;
            busy     <= 1'b1;
            win_q    <= win_c;
            ack      <= ACK_ONE << win_c;
            mem_addr <= addr_c;
            mem_data <= ch_data[win_c];
            // The reserved slot is consumed and counted, only the strobe is withheld.
            mem_we   <= (addr_c != RSVD_ADDR);
            if (addr_c == RSVD_ADDR) err <= 1'b1;
`ifndef DMA_SCHED_FIXED_PRIO_EN
            rr_ptr   <= (win_c == LAST_CH) ? '0 : win_c + IDX_ONE;
`endif
          end
        end
        WRITE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ack    <= '0;
          mem_we <= 1'b0;
          if (!cfg_hits_win) begin
            cnt[win_q] <= cnt_nxt;
            if (cnt_nxt == len[win_q]) begin
              active[win_q] <= 1'b0;
              done[win_q]   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a reprogram of the channel in WRITE overrides its post-increment.
      if (cfg_we) begin
        base[cfg_ch]   <= cfg_base;
        len[cfg_ch]    <= cfg_len;
        cnt[cfg_ch]    <= '0;
        active[cfg_ch] <= (cfg_len != '0);
      end
    end
  end
endmodule

// File: tb/tb_dma_scheduler.sv
// tb/tb_dma_scheduler.sv - scoreboard bench for dma_scheduler
module tb_dma_scheduler;
  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;

  logic              clock_reg = 1'b0;
  logic              reset     = 1'b0;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data_in;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [AW-1:0]     cfg_base;
  logic [AW-1:0]     cfg_len;
  logic [NCH-1:0]    ack;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic [NCH-1:0]    done;
  logic              busy;
  logic              err;

  dma_scheduler #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_reg(clock_reg), .reset(reset), .req(req), .data_in(data_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .ack(ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clock_reg = ~clock_reg;

  typedef struct {
    int         ch;
    logic [7:0] addr;
    logic [7:0] data;
    logic       we;
  } exp_t;

  exp_t           sb[$];
  int             gcyc[$];
  int             errors = 0;
  int             checks = 0;
  int             cycles = 0;
  int             done_cnt[NCH];
  int             left[NCH];
  int             seq[NCH];
  logic [NCH-1:0] hold;

  function automatic logic [7:0] dval(int ch, int n);
    return 8'(8'hA1 + ch * 16 + n);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock_reg);
    #1;
    cycles++;
    for (int i = 0; i < NCH; i++) if (done[i]) done_cnt[i]++;
    if (ack == '0) begin
      chk("idle_we", mem_we, 0);
    end else if (sb.size() == 0) begin
      chk("unexpected_ack", ack, 0);
    end else begin
      e = sb.pop_front();
      chk("ack", ack, 1 << e.ch);
      chk("addr", mem_addr, e.addr);
      chk("data", mem_data, e.data);
      chk("we", mem_we, e.we);
      chk("busy", busy, 1);
      gcyc.push_back(cycles);
      for (int i = 0; i < NCH; i++) begin
        if (ack[i]) begin
          seq[i]++;
          left[i]--;
          if (left[i] <= 0 && !hold[i]) req[i] = 1'b0;
          else data_in[i*DW +: DW] = dval(i, seq[i]);
        end
      end
    end
  endtask

  task automatic push(int ch, logic [7:0] a0, int s0, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ch   = ch;
      e.addr = 8'(int'(a0) + k);
      e.data = dval(ch, s0 + k);
      e.we   = (e.addr != 8'hFF);
      sb.push_back(e);
    end
  endtask

  task automatic arm(int ch, int n, logic h);
    left[ch]             = n;
    seq[ch]              = 0;
    hold[ch]             = h;
    data_in[ch*DW +: DW] = dval(ch, 0);
    req[ch]              = 1'b1;
  endtask

  task automatic cfg(int ch, logic [7:0] b, logic [7:0] l);
    cfg_ch   = 2'(ch);
    cfg_base = b;
    cfg_len  = l;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic drain(int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) tick();
    chk("drain_sb", sb.size(), 0);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req      = '0;
    data_in  = '0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_base = '0;
    cfg_len  = '0;
    hold     = '0;
    sb.delete();
    gcyc.delete();
    for (int i = 0; i < NCH; i++) begin
      done_cnt[i] = 0;
      left[i]     = 0;
      seq[i]      = 0;
    end
    @(posedge clock_reg);
    #2 reset = 1'b1;
  endtask

  initial begin
    // Reset state and a simple 3-beat window on ch0 with req held past the end.
    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    cfg(0, 8'h10, 8'd3);
    push(0, 8'h10, 0, 3);
    arm(0, 3, 1'b1);
    drain(40);
    repeat (6) tick();
    chk("t1_done_cnt", done_cnt[0], 1);
    chk("t1_grants", gcyc.size(), 3);
    if (gcyc.size() == 3) begin
      chk("t1_gap0", gcyc[1] - gcyc[0], 2);
      chk("t1_gap1", gcyc[2] - gcyc[1], 2);
    end
    req[0] = 1'b0;

    // Two channels competing.
    do_reset();
    cfg(0, 8'h20, 8'd4);
    cfg(1, 8'h30, 8'd4);
`ifdef DMA_SCHED_FIXED_PRIO_EN
    push(0, 8'h20, 0, 4);
    push(1, 8'h30, 0, 4);
`else
    for (int k = 0; k < 4; k++) begin
      push(0, 8'(8'h20 + k), k, 1);
      push(1, 8'(8'h30 + k), k, 1);
    end
`endif
    arm(0, 4, 1'b0);
    arm(1, 4, 1'b0);
    drain(60);
    chk("t2_done0", done_cnt[0], 1);
    chk("t2_done1", done_cnt[1], 1);

    // Window crossing the reserved address.
    do_reset();
    cfg(2, 8'hFE, 8'd3);
    chk("t3_err_pre", err, 0);
    push(2, 8'hFE, 0, 3);
    arm(2, 3, 1'b0);
    drain(40);
    chk("t3_err", err, 1);
    chk("t3_done2", done_cnt[2], 1);

    // Request on an unarmed channel.
    do_reset();
    req[3] = 1'b1;
    data_in[3*DW +: DW] = 8'h5A;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_ack", ack, 0);
      chk("t4_we", mem_we, 0);
      chk("t4_busy", busy, 0);
    end
    req[3] = 1'b0;

    // Reprogram of ch0 landing on its WRITE cycle.
    do_reset();
    cfg(0, 8'h50, 8'd1);
    push(0, 8'h50, 0, 1);
    push(0, 8'h40, 1, 2);
    arm(0, 3, 1'b0);
    for (int k = 0; k < 10 && ack[0] == 1'b0; k++) tick();
    chk("t5_first_ack", ack[0], 1);
    cfg(0, 8'h40, 8'd2);
    chk("t5_no_done", done[0], 0);
    drain(40);
    chk("t5_done_cnt", done_cnt[0], 1);

    // Reset asserted mid-transfer.
    do_reset();
    cfg(1, 8'h60, 8'd4);
    push(1, 8'h60, 0, 1);
    arm(1, 4, 1'b0);
    for (int k = 0; k < 10 && ack[1] == 1'b0; k++) tick();
    chk("t6_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_ack", ack, 0);
    chk("t6_we", mem_we, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_data", mem_data, 0);
    chk("t6_done", done, 0);
    chk("t6_busy0", busy, 0);
    chk("t6_err", err, 0);
    @(posedge clock_reg);
    #2 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_post_ack", ack, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
